frame_stream_controller: RTL and testbench
==========================================

# frame_stream_controller

Frame-level sequencer placed in front of the pixel-processing datapath, the `top` block with `input_data`/`input_data_valid` in and `output_data`/`output_data_valid` out. On a `start` command it admits exactly one IMAGE_WIDTH×IMAGE_HEIGHT frame of raster-order pixels and forwards each pixel with its column/line position and frame markers. It counts the datapath's valid results and reports frame completion, or a drain timeout if the datapath stalls. Pixels arriving outside an admitted frame are dropped and flagged.

## Interface
- PX_SIZE, 8, pixel width in bits
- IMAGE_WIDTH, 64, pixels per line
- IMAGE_HEIGHT, 64, lines per frame
- CNT_W, 12, width of the column and line counters; must satisfy 2^CNT_W > max(IMAGE_WIDTH, IMAGE_HEIGHT)
- DRAIN_TIMEOUT, 256, consecutive result-less DRAIN cycles before abort
- clk  in  1  single clock; all logic rising-edge
- resetn  in  1  reset, synchronous, active-high (1 = reset)
- start  in  1  frame request, sampled in IDLE only
- in_data  in  PX_SIZE  incoming pixel
- in_valid  in  1  in_data valid this cycle
- dp_data  out  PX_SIZE  pixel to the datapath (drives its `input_data`)
- dp_valid  out  1  to the datapath's `input_data_valid`
- dp_x  out  CNT_W  column of dp_data
- dp_y  out  CNT_W  line of dp_data
- dp_sof  out  1  dp_data is pixel (0,0)
- dp_eol  out  1  dp_data is the last pixel of a line
- dp_eof  out  1  dp_data is the last pixel of the frame
- res_valid  in  1  datapath's `output_data_valid`
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse at frame end
- err_timeout  out  1  sticky; set on drain timeout, cleared on an accepted start
- in_dropped  out  1  one-cycle pulse, in_valid seen outside ACTIVE

## Operation
- States: IDLE, ACTIVE, DRAIN, DONE.
- IDLE → ACTIVE on start=1. Same edge: x_cnt, y_cnt, res_cnt, to_cnt ← 0; err_timeout ← 0.
- ACTIVE: each in_valid=1 cycle registers dp_data=in_data, dp_x=x_cnt, dp_y=y_cnt, dp_sof=(x=0 && y=0), dp_eol=(x=W-1), dp_eof=(x=W-1 && y=H-1).
- ACTIVE counter update: x_cnt wraps W-1→0 and increments y_cnt on the wrap. Accepting pixel (W-1,H-1) moves to DRAIN.
- res_cnt: increments on res_valid in ACTIVE or DRAIN. Saturates at W*H; surplus results are ignored. Its width is sized to hold W*H.
- DRAIN: res_cnt reaching W*H (including the count from the current res_valid) → DONE.
- DRAIN timeout: to_cnt increments each cycle with res_valid=0 and clears on res_valid=1. When to_cnt reaches DRAIN_TIMEOUT-1 with no result that cycle: err_timeout ← 1, → DONE.
- DONE: frame_done=1 for exactly this cycle, then → IDLE unconditionally. start in DONE is ignored.
- start in ACTIVE or DRAIN is ignored and does not restart counters.
- in_valid=1 in IDLE, DRAIN or DONE: pixel discarded, in_dropped=1 the next cycle, dp_valid stays 0.
- Reset at any point: state IDLE, all counters 0, the in-flight frame abandoned.

## Timing
- Reset values: dp_data=0, dp_valid=0, dp_x=0, dp_y=0, dp_sof=0, dp_eol=0, dp_eof=0, busy=0, frame_done=0, err_timeout=0, in_dropped=0.
- in → dp latency: 1 cycle. dp_* outputs are registered. dp_valid=0 in cycles without an accepted pixel; dp_data then holds its last value.
- Pixel throughput: one pixel per cycle. Gaps in in_valid are allowed and do not advance counters.
- First pixel: a pixel with in_valid=1 in the first cycle after start was sampled is accepted. A pixel coincident with the start edge is dropped.
- frame_done rises the cycle after the edge on which res_cnt reached W*H or the timeout fired.
- busy rises the cycle after start is sampled and falls the cycle after DONE.
- frame_done is Moore (state==DONE); in_dropped is registered.

## Test plan
- W=4, H=2, start, then 8 contiguous pixels 1..8; datapath echoes with 1-cycle latency → dp_x/dp_y sequence (0,0)…(3,1); dp_sof with pixel 1, dp_eol with pixels 4 and 8, dp_eof with pixel 8; frame_done one cycle after the 8th res_valid; err_timeout=0.
- Same frame with in_valid toggling 1/0 → identical tags; counters hold during gaps; frame_done after the 8th result.
- W=4, H=2, DRAIN_TIMEOUT=16: datapath returns only 5 results, then stays silent → err_timeout=1 and frame_done pulse 16 cycles after the last result. A following start clears err_timeout.
- in_valid=1 in IDLE and while in DRAIN → in_dropped pulses, dp_valid stays 0, and x/y of the next frame start at (0,0).
- start asserted mid-ACTIVE after 3 pixels → ignored; the frame completes normally. resetn=1 after 5 pixels → all outputs 0 next cycle, then a new start streams from (0,0).
- Datapath emits 10 results for an 8-pixel frame → frame_done once, res_cnt holds at 8, no second pulse.

Source files
------------

// File: rtl/frame_stream_controller_if.sv
// Pixel stream bus between the frame controller and its neighbours: raw pixels in,
// tagged pixels out to the datapath, and the datapath's result strobe back.
interface frame_stream_controller_if #(
  parameter int PX_SIZE = 8,
  parameter int CNT_W   = 12
);
  logic [PX_SIZE-1:0] in_data;
  logic               in_valid;
  logic [PX_SIZE-1:0] dp_data;
  logic               dp_valid;
  logic [CNT_W-1:0]   dp_x;
  logic [CNT_W-1:0]   dp_y;
  logic               dp_sof;
  logic               dp_eol;
  logic               dp_eof;
  logic               res_valid;

  // Controller side.
  modport master (
    input  in_data, in_valid, res_valid,
    output dp_data, dp_valid, dp_x, dp_y, dp_sof, dp_eol, dp_eof
  );

  // Pixel source / datapath side.
  modport slave (
    output in_data, in_valid, res_valid,
    input  dp_data, dp_valid, dp_x, dp_y, dp_sof, dp_eol, dp_eof
  );
endinterface

// File: rtl/frame_stream_controller.sv
// Admits one raster frame per start command, tags each pixel with its position,
// counts datapath results and reports completion or a drain timeout.
module frame_stream_controller #(
  parameter int PX_SIZE       = 8,
  parameter int IMAGE_WIDTH   = 64,
  parameter int IMAGE_HEIGHT  = 64,
  parameter int CNT_W         = 12,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  frame_stream_controller_if.master bus,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_timeout,
  output logic                      in_dropped
);

  localparam int FRAME_PX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int RES_W    = $clog2(FRAME_PX + 1);
  localparam int TO_W     = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(IMAGE_HEIGHT - 1);
  localparam logic [RES_W-1:0] RES_FULL = RES_W'(FRAME_PX);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   x_cnt_q;
  logic [CNT_W-1:0]   y_cnt_q;
  logic [RES_W-1:0]   res_cnt_q;
  logic [RES_W-1:0]   res_cnt_d;
  logic [TO_W-1:0]    to_cnt_q;
  logic [PX_SIZE-1:0] dp_data_q;
  logic               dp_valid_q;
  logic [CNT_W-1:0]   dp_x_q;
  logic [CNT_W-1:0]   dp_y_q;
  logic               dp_sof_q;
  logic               dp_eol_q;
  logic               dp_eof_q;
  logic               err_timeout_q;
  logic               in_dropped_q;

  logic px_take;
  logic res_take;
  logic x_last;
  logic y_last;

  always_comb begin
    px_take  = bus.in_valid && (state_q == ACTIVE);
    x_last   = (x_cnt_q == X_LAST);
    y_last   = (y_cnt_q == Y_LAST);
    // Results beyond one frame's worth are ignored so the count saturates.
    res_take = bus.res_valid && ((state_q == ACTIVE) || (state_q == DRAIN))
               && (res_cnt_q != RES_FULL);
    res_cnt_d = res_take ? (res_cnt_q + RES_W'(1)) : res_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q       <= IDLE;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      res_cnt_q     <= '0;
      to_cnt_q      <= '0;
      dp_data_q     <= '0;
      dp_valid_q    <= 1'b0;
      dp_x_q        <= '0;
      dp_y_q        <= '0;
      dp_sof_q      <= 1'b0;
      dp_eol_q      <= 1'b0;
      dp_eof_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      in_dropped_q  <= 1'b0;
    end else begin
      dp_valid_q   <= px_take;
      in_dropped_q <= bus.in_valid && (state_q != ACTIVE);
      res_cnt_q    <= res_cnt_d;

      if (px_take) begin
        dp_data_q <= bus.in_data;
        dp_x_q    <= x_cnt_q;
        dp_y_q    <= y_cnt_q;
        dp_sof_q  <= (x_cnt_q == '0) && (y_cnt_q == '0);
        dp_eol_q  <= x_last;
        dp_eof_q  <= x_last && y_last;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= ACTIVE;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            res_cnt_q     <= '0;
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
          end
        end

        ACTIVE: begin
          if (px_take) begin
            if (x_last) begin
              x_cnt_q <= '0;
              if (y_last) begin
                state_q <= DRAIN;
              end else begin
                y_cnt_q <= y_cnt_q + CNT_W'(1);
              end
            end else begin
              x_cnt_q <= x_cnt_q + CNT_W'(1);
            end
          end
        end

        DRAIN: begin
          // Completion wins over the timeout when the final result lands on the last cycle.
          if (res_cnt_d == RES_FULL) begin
            state_q <= DONE;
          end else if (bus.res_valid) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded straight from the state register.
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign err_timeout = err_timeout_q;
  assign in_dropped  = in_dropped_q;

  assign bus.dp_data  = dp_data_q;
  assign bus.dp_valid = dp_valid_q;
  assign bus.dp_x     = dp_x_q;
  assign bus.dp_y     = dp_y_q;
  assign bus.dp_sof   = dp_sof_q;
  assign bus.dp_eol   = dp_eol_q;
  assign bus.dp_eof   = dp_eof_q;

endmodule

// File: tb/tb_frame_stream_controller.sv
// Scoreboard bench for frame_stream_controller on a 4x2 frame with a 16-cycle drain timeout.
module tb_frame_stream_controller;

  localparam int PX = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 12;
  localparam int DT = 16;

  typedef struct packed {
    logic [PX-1:0] d;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic start  = 1'b0;
  logic busy, frame_done, err_timeout, in_dropped;

  frame_stream_controller_if #(.PX_SIZE(PX), .CNT_W(CW)) bus ();

  frame_stream_controller #(
    .PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CNT_W(CW), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .bus(bus.master),
    .busy(busy),
    .frame_done(frame_done),
    .err_timeout(err_timeout),
    .in_dropped(in_dropped)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   echo_left = 0;
  int   last_res_cyc = 0;
  logic res_pipe = 1'b0;
  logic res_force = 1'b0;
  int   mx = 0;
  int   my = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_got;

  // Scoreboard: every dp_valid cycle must match the oldest expected pixel.
  always @(negedge clk) begin
    if (bus.dp_valid === 1'b1) begin
      mon_got = '{d: bus.dp_data, x: bus.dp_x, y: bus.dp_y,
                  sof: bus.dp_sof, eol: bus.dp_eol, eof: bus.dp_eof};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dp_unexpected: got d=%0d x=%0d y=%0d, required no pixel",
                 mon_got.d, mon_got.x, mon_got.y);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL dp_pixel: got d=%0d x=%0d y=%0d sof=%0b eol=%0b eof=%0b, required d=%0d x=%0d y=%0d sof=%0b eol=%0b eof=%0b",
                   mon_got.d, mon_got.x, mon_got.y, mon_got.sof, mon_got.eol, mon_got.eof,
                   mon_e.d, mon_e.x, mon_e.y, mon_e.sof, mon_e.eol, mon_e.eof);
        end else begin
          $display("px d=%0d x=%0d y=%0d sof=%0b eol=%0b eof=%0b",
                   mon_got.d, mon_got.x, mon_got.y, mon_got.sof, mon_got.eol, mon_got.eof);
        end
      end
    end
  end

  // One clock; the datapath model echoes dp_valid back as res_valid one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if ((res_pipe && echo_left > 0) || res_force) begin
      bus.res_valid = 1'b1;
      last_res_cyc  = cyc;
      if (res_pipe && echo_left > 0) echo_left--;
    end else begin
      bus.res_valid = 1'b0;
    end
    res_pipe = bus.dp_valid;
  endtask

  task automatic send_px(input logic [PX-1:0] d, input bit accept);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (accept) begin
      e.d   = d;
      e.x   = CW'(mx);
      e.y   = CW'(my);
      e.sof = (mx == 0) && (my == 0);
      e.eol = (mx == W - 1);
      e.eof = (mx == W - 1) && (my == H - 1);
      exp_q.push_back(e);
      if (mx == W - 1) begin
        mx = 0;
        my = my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    mx = 0;
    my = 0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (frame_done === 1'b1) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.dp_valid, busy, frame_done, err_timeout, in_dropped} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.dp_valid, busy, frame_done, err_timeout, in_dropped});
    end
    checks++;
    if ({bus.dp_data, bus.dp_x, bus.dp_y, bus.dp_sof, bus.dp_eol, bus.dp_eof} !== '0) begin
      errors++;
      $display("FAIL reset_dp: got d=%0d x=%0d y=%0d, required all zero",
               bus.dp_data, bus.dp_x, bus.dp_y);
    end
    resetn = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int at;
    echo_left = 8;
    begin_frame();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b, required 1", busy);
    end
    for (int p = 1; p <= 8; p++) send_px(PX'(p), 1'b1);
    wait_done(40, at);
    checks++;
    if (at !== last_res_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d, required %0d", at, last_res_cyc + 1);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b, required 0", err_timeout);
    end
    step();
    checks++;
    if ({frame_done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_after_done: got done=%b busy=%b, required 0 0", frame_done, busy);
    end
  endtask

  task automatic test_gaps();
    int at;
    echo_left = 8;
    begin_frame();
    for (int p = 1; p <= 8; p++) begin
      send_px(PX'(p + 16), 1'b1);
      step();
    end
    wait_done(40, at);
    checks++;
    if (at !== last_res_cyc + 1) begin
      errors++;
      $display("FAIL gaps_done_cycle: got %0d, required %0d", at, last_res_cyc + 1);
    end
    step();
  endtask

  task automatic test_timeout();
    int at;
    int early;
    echo_left = 0;
    begin_frame();
    for (int p = 1; p <= 8; p++) send_px(PX'(p + 32), 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      res_force = 1'b1;
      step();
    end
    res_force = 1'b0;
    early = 0;
    for (int k = 1; k <= DT; k++) begin
      step();
      if (frame_done === 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d pulses in %0d silent cycles, required 0", early, DT);
    end
    step();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: got %b, required 1", frame_done);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_set: got %b, required 1", err_timeout);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_sticky: got %b, required 1", err_timeout);
    end
    echo_left = 8;
    begin_frame();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: got %b, required 0", err_timeout);
    end
    for (int p = 1; p <= 8; p++) send_px(PX'(p + 48), 1'b1);
    wait_done(40, at);
    checks++;
    if (at !== last_res_cyc + 1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got done at %0d err=%b, required %0d err=0",
               at, err_timeout, last_res_cyc + 1);
    end
    step();
  endtask

  task automatic test_drop();
    int at;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({in_dropped, bus.dp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL drop_idle: got dropped=%b dp_valid=%b, required 1 0", in_dropped, bus.dp_valid);
    end
    step();
    checks++;
    if (in_dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse_width: got %b, required 0", in_dropped);
    end
    echo_left = 0;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hBB;
    step();
    start = 1'b0;
    bus.in_valid = 1'b0;
    mx = 0;
    my = 0;
    checks++;
    if ({in_dropped, bus.dp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL drop_start_edge: got dropped=%b dp_valid=%b, required 1 0", in_dropped, bus.dp_valid);
    end
    for (int p = 1; p <= 8; p++) send_px(PX'(p + 64), 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hCC;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({in_dropped, bus.dp_valid, busy} !== 3'b101) begin
      errors++;
      $display("FAIL drop_drain: got dropped=%b dp_valid=%b busy=%b, required 1 0 1",
               in_dropped, bus.dp_valid, busy);
    end
    for (int i = 0; i < 8; i++) begin
      res_force = 1'b1;
      step();
    end
    res_force = 1'b0;
    wait_done(10, at);
    checks++;
    if (at !== last_res_cyc + 1) begin
      errors++;
      $display("FAIL drop_done_cycle: got %0d, required %0d", at, last_res_cyc + 1);
    end
    step();
    echo_left = 8;
    begin_frame();
    for (int p = 1; p <= 8; p++) send_px(PX'(p + 80), 1'b1);
    wait_done(40, at);
    checks++;
    if (at !== last_res_cyc + 1) begin
      errors++;
      $display("FAIL drop_next_frame: got %0d, required %0d", at, last_res_cyc + 1);
    end
    step();
  endtask

  task automatic test_restart_and_reset();
    int at;
    echo_left = 8;
    begin_frame();
    for (int p = 1; p <= 3; p++) send_px(PX'(p + 96), 1'b1);
    start = 1'b1;
    send_px(PX'(100), 1'b1);
    start = 1'b0;
    for (int p = 5; p <= 8; p++) send_px(PX'(p + 96), 1'b1);
    wait_done(40, at);
    checks++;
    if (at !== last_res_cyc + 1) begin
      errors++;
      $display("FAIL restart_done_cycle: got %0d, required %0d", at, last_res_cyc + 1);
    end
    step();
    echo_left = 8;
    begin_frame();
    for (int p = 1; p <= 5; p++) send_px(PX'(p + 112), 1'b1);
    resetn = 1'b1;
    step();
    checks++;
    if ({bus.dp_data, bus.dp_valid, bus.dp_x, bus.dp_y, bus.dp_sof, bus.dp_eol, bus.dp_eof,
         busy, frame_done, err_timeout, in_dropped} !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame: got d=%0d v=%b x=%0d y=%0d busy=%b done=%b, required all zero",
               bus.dp_data, bus.dp_valid, bus.dp_x, bus.dp_y, busy, frame_done);
    end
    resetn = 1'b0;
    echo_left = 0;
    step();
    echo_left = 8;
    begin_frame();
    for (int p = 1; p <= 8; p++) send_px(PX'(p + 128), 1'b1);
    wait_done(40, at);
    checks++;
    if (at !== last_res_cyc + 1) begin
      errors++;
      $display("FAIL reset_new_frame: got %0d, required %0d", at, last_res_cyc + 1);
    end
    step();
  endtask

  task automatic test_surplus();
    int pulses;
    int first;
    int r8;
    echo_left = 0;
    begin_frame();
    for (int p = 1; p <= 8; p++) send_px(PX'(p + 144), 1'b1);
    pulses = 0;
    first  = -1;
    r8     = -1;
    for (int i = 0; i < 30; i++) begin
      res_force = (i < 10);
      step();
      if (i == 7) r8 = cyc;
      if (frame_done === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    res_force = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL surplus_pulses: got %0d, required 1", pulses);
    end
    checks++;
    if (first !== r8 + 1) begin
      errors++;
      $display("FAIL surplus_done_cycle: got %0d, required %0d", first, r8 + 1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_valid = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_timeout();
    test_drop();
    test_restart_and_reset();
    test_surplus();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending pixels, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
